// File: rtl/match_controller_if.sv
// Signal bundle between the hit detector / display side and match_controller.
interface match_controller_if;
  logic       start;
  logic       player_1_hit;
  logic       player_2_hit;
  logic       bullet_on_bullet_hit;
  logic       armor_hit;
  logic [2:0] state;
  logic       freeze;
  logic       bullet_1_clear;
  logic       bullet_2_clear;
  logic [3:0] p1_lives;
  logic [3:0] p2_lives;
  logic       p1_invuln;
  logic       p2_invuln;
  logic [1:0] winner;
  logic [7:0] countdown;

  modport master (
    output start, player_1_hit, player_2_hit, bullet_on_bullet_hit, armor_hit,
    input  state, freeze, bullet_1_clear, bullet_2_clear, p1_lives, p2_lives,
           p1_invuln, p2_invuln, winner, countdown
  );

  modport slave (
    input  start, player_1_hit, player_2_hit, bullet_on_bullet_hit, armor_hit,
    output state, freeze, bullet_1_clear, bullet_2_clear, p1_lives, p2_lives,
           p1_invuln, p2_invuln, winner, countdown
  );
endinterface

// File: rtl/match_controller.sv
// Match flow controller: edge-qualifies hit flags, tracks lives and invulnerability,
// and sequences idle / countdown / play / hit-pause / game-over once per frame.
module match_controller #(
  parameter int unsigned LIVES            = 3,
  parameter int unsigned INVULN_FRAMES    = 60,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned HIT_PAUSE_FRAMES = 30
) (
  input logic               frame_clk,
  input logic               Reset,
  match_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    HIT_PAUSE = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  localparam logic [3:0] LIVES_INIT  = 4'(LIVES);
  localparam logic [7:0] INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [7:0] CD_INIT     = 8'(COUNTDOWN_FRAMES - 1);
  localparam logic [7:0] HP_INIT     = 8'(HIT_PAUSE_FRAMES - 1);

  state_e     state_q, state_d;
  logic [3:0] p1_lives_q, p1_lives_d;
  logic [3:0] p2_lives_q, p2_lives_d;
  logic [7:0] p1_inv_q, p1_inv_d;
  logic [7:0] p2_inv_q, p2_inv_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] countdown_q, countdown_d;
  logic       clear_1_q, clear_1_d;
  logic       clear_2_q, clear_2_d;

  logic       start_prev_q, p1_hit_prev_q, p2_hit_prev_q, bob_prev_q, armor_prev_q;

  logic       start_edge, p1_edge, p2_edge, bob_edge, armor_edge;
  logic       in_play, p1_accept, p2_accept, bullet_event;
  logic       p1_out, p2_out;

  always_comb begin
    start_edge   = bus.start & ~start_prev_q;
    p1_edge      = bus.player_1_hit & ~p1_hit_prev_q;
    p2_edge      = bus.player_2_hit & ~p2_hit_prev_q;
    bob_edge     = bus.bullet_on_bullet_hit & ~bob_prev_q;
    armor_edge   = bus.armor_hit & ~armor_prev_q;

    in_play      = (state_q == PLAY);
    p1_accept    = in_play & p1_edge & (p1_inv_q == '0);
    p2_accept    = in_play & p2_edge & (p2_inv_q == '0);
    bullet_event = in_play & (bob_edge | armor_edge);
  end

  // Each bullet is cleared when it lands on the opposing player.
  always_comb begin
    clear_1_d = p2_accept | bullet_event;
    clear_2_d = p1_accept | bullet_event;
  end

  always_comb begin
    p1_inv_d = p1_inv_q;
    p2_inv_d = p2_inv_q;
    if (state_q == IDLE) begin
      p1_inv_d = '0;
      p2_inv_d = '0;
    end else begin
      if (p1_accept)             p1_inv_d = INVULN_INIT;
      else if (p1_inv_q != '0)   p1_inv_d = p1_inv_q - 8'd1;
      if (p2_accept)             p2_inv_d = INVULN_INIT;
      else if (p2_inv_q != '0)   p2_inv_d = p2_inv_q - 8'd1;
    end
  end

  // Lives take the saturating hit decrement by default so the PLAY branch can
  // judge the post-hit count; start edges override with a reload.
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    countdown_d = countdown_q;
    p1_lives_d  = p1_lives_q;
    p2_lives_d  = p2_lives_q;
    if (p1_accept && (p1_lives_q != '0)) p1_lives_d = p1_lives_q - 4'd1;
    if (p2_accept && (p2_lives_q != '0)) p2_lives_d = p2_lives_q - 4'd1;
    p1_out = p1_accept & (p1_lives_d == '0);
    p2_out = p2_accept & (p2_lives_d == '0);

    unique case (state_q)
      IDLE: begin
        countdown_d = '0;
        if (start_edge) begin
          p1_lives_d  = LIVES_INIT;
          p2_lives_d  = LIVES_INIT;
          winner_d    = '0;
          countdown_d = CD_INIT;
          state_d     = COUNTDOWN;
        end
      end
      COUNTDOWN, HIT_PAUSE: begin
        if (countdown_q == '0) state_d = PLAY;
        else                   countdown_d = countdown_q - 8'd1;
      end
      PLAY: begin
        countdown_d = '0;
        if (p1_out || p2_out) begin
          winner_d = {p1_out, p2_out};
          state_d  = GAME_OVER;
        end else if (p1_accept || p2_accept) begin
          countdown_d = HP_INIT;
          state_d     = HIT_PAUSE;
        end
      end
      GAME_OVER: begin
        countdown_d = '0;
        if (start_edge) begin
          p1_lives_d  = LIVES_INIT;
          p2_lives_d  = LIVES_INIT;
          winner_d    = '0;
          countdown_d = CD_INIT;
          state_d     = COUNTDOWN;
        end
      end
      default: begin
        countdown_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      p1_lives_q    <= LIVES_INIT;
      p2_lives_q    <= LIVES_INIT;
      p1_inv_q      <= '0;
      p2_inv_q      <= '0;
      winner_q      <= '0;
      countdown_q   <= '0;
      clear_1_q     <= 1'b0;
      clear_2_q     <= 1'b0;
      start_prev_q  <= 1'b0;
      p1_hit_prev_q <= 1'b0;
      p2_hit_prev_q <= 1'b0;
      bob_prev_q    <= 1'b0;
      armor_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      p1_lives_q    <= p1_lives_d;
      p2_lives_q    <= p2_lives_d;
      p1_inv_q      <= p1_inv_d;
      p2_inv_q      <= p2_inv_d;
      winner_q      <= winner_d;
      countdown_q   <= countdown_d;
      clear_1_q     <= clear_1_d;
      clear_2_q     <= clear_2_d;
      start_prev_q  <= bus.start;
      p1_hit_prev_q <= bus.player_1_hit;
      p2_hit_prev_q <= bus.player_2_hit;
      bob_prev_q    <= bus.bullet_on_bullet_hit;
      armor_prev_q  <= bus.armor_hit;
    end
  end

  assign bus.state          = state_q;
  assign bus.freeze         = (state_q != PLAY);
  assign bus.bullet_1_clear = clear_1_q;
  assign bus.bullet_2_clear = clear_2_q;
  assign bus.p1_lives       = p1_lives_q;
  assign bus.p2_lives       = p2_lives_q;
  assign bus.p1_invuln      = (p1_inv_q != '0);
  assign bus.p2_invuln      = (p2_inv_q != '0);
  assign bus.winner         = winner_q;
  assign bus.countdown      = countdown_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed game-flow scenarios followed by random level stimulus, every frame
// compared against a rule-level model of the match.
module tb_match_controller;
  localparam int LIVES = 3;
  localparam int INV   = 60;
  localparam int CDF   = 180;
  localparam int HPF   = 30;

  localparam int ST_IDLE = 0, ST_CD = 1, ST_PLAY = 2, ST_HP = 3, ST_GO = 4;

  logic frame_clk = 1'b0;
  logic Reset;
  match_controller_if bus ();

  match_controller #(
    .LIVES(LIVES), .INVULN_FRAMES(INV), .COUNTDOWN_FRAMES(CDF), .HIT_PAUSE_FRAMES(HPF)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int checks, errors;
  int n, hp, pulses, pulses2, bound;

  // Rule-level model of the match
  int m_state, m_cd, m_win;
  int m_lives [2];
  int m_inv   [2];
  bit m_clr   [2];
  bit m_prev  [5];

  task automatic model_reset();
    m_state = ST_IDLE; m_cd = 0; m_win = 0;
    for (int i = 0; i < 2; i++) begin
      m_lives[i] = LIVES; m_inv[i] = 0; m_clr[i] = 0;
    end
    for (int i = 0; i < 5; i++) m_prev[i] = 0;
  endtask

  task automatic model_new_match();
    m_lives[0] = LIVES; m_lives[1] = LIVES;
    m_win = 0; m_cd = CDF - 1; m_state = ST_CD;
  endtask

  task automatic model_step(input bit s, input bit h1, input bit h2, input bit bob, input bit arm);
    bit e_s, ev;
    bit e_hit [2];
    bit acc   [2];
    bit dead  [2];
    int st;
    st       = m_state;
    e_s      = s && !m_prev[0];
    e_hit[0] = h1 && !m_prev[1];
    e_hit[1] = h2 && !m_prev[2];
    ev       = (bob && !m_prev[3]) || (arm && !m_prev[4]);
    for (int i = 0; i < 2; i++) begin
      acc[i] = (st == ST_PLAY) && e_hit[i] && (m_inv[i] == 0);
      if (st == ST_IDLE)    m_inv[i] = 0;
      else if (acc[i])      m_inv[i] = INV;
      else if (m_inv[i] > 0) m_inv[i] = m_inv[i] - 1;
      if (acc[i] && m_lives[i] > 0) m_lives[i] = m_lives[i] - 1;
      dead[i] = acc[i] && (m_lives[i] == 0);
    end
    m_clr[0] = acc[1] || ((st == ST_PLAY) && ev);
    m_clr[1] = acc[0] || ((st == ST_PLAY) && ev);
    case (st)
      ST_IDLE: if (e_s) model_new_match();
      ST_CD, ST_HP: begin
        if (m_cd == 0) m_state = ST_PLAY;
        else           m_cd = m_cd - 1;
      end
      ST_PLAY: begin
        if (dead[0] || dead[1]) begin
          m_state = ST_GO;
          m_win   = (dead[0] ? 2 : 0) + (dead[1] ? 1 : 0);
        end else if (acc[0] || acc[1]) begin
          m_cd = HPF - 1; m_state = ST_HP;
        end
      end
      ST_GO: if (e_s) model_new_match();
      default: m_state = ST_IDLE;
    endcase
    m_prev[0] = s; m_prev[1] = h1; m_prev[2] = h2; m_prev[3] = bob; m_prev[4] = arm;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("state",     32'(bus.state),          32'(m_state));
    chk("freeze",    32'(bus.freeze),         32'(m_state != ST_PLAY));
    chk("p1_lives",  32'(bus.p1_lives),       32'(m_lives[0]));
    chk("p2_lives",  32'(bus.p2_lives),       32'(m_lives[1]));
    chk("p1_invuln", 32'(bus.p1_invuln),      32'(m_inv[0] != 0));
    chk("p2_invuln", 32'(bus.p2_invuln),      32'(m_inv[1] != 0));
    chk("clear1",    32'(bus.bullet_1_clear), 32'(m_clr[0]));
    chk("clear2",    32'(bus.bullet_2_clear), 32'(m_clr[1]));
    chk("winner",    32'(bus.winner),         32'(m_win));
    chk("countdown", 32'(bus.countdown),      32'(m_cd));
  endtask

  task automatic tick(input bit r, input bit s, input bit h1, input bit h2,
                      input bit bob, input bit arm);
    Reset = r;
    bus.start = s; bus.player_1_hit = h1; bus.player_2_hit = h2;
    bus.bullet_on_bullet_hit = bob; bus.armor_hit = arm;
    @(posedge frame_clk);
    if (r) model_reset();
    else   model_step(s, h1, h2, bob, arm);
    #1;
    compare_all();
  endtask

  task automatic idle_frames(input int cnt);
    for (int i = 0; i < cnt; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_countdown();
    n = 0;
    while (bus.state == 3'd1 && n < 400) begin
      n++;
      tick(0, 0, 0, 0, 0, 0);
    end
    chk("cd_dwell", 32'(n), 32'(CDF));
    chk("cd_to_play", 32'(bus.state), 32'(ST_PLAY));
  endtask

  initial begin
    bit rs, s, h1, h2, bob, arm;
    checks = 0; errors = 0;
    Reset = 1'b1;
    bus.start = 0; bus.player_1_hit = 0; bus.player_2_hit = 0;
    bus.bullet_on_bullet_hit = 0; bus.armor_hit = 0;
    model_reset();

    // Reset for two frames, then release
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("rst_state",  32'(bus.state), 0);
    chk("rst_freeze", 32'(bus.freeze), 1);
    chk("rst_p1",     32'(bus.p1_lives), 3);
    chk("rst_p2",     32'(bus.p2_lives), 3);
    chk("rst_winner", 32'(bus.winner), 0);
    chk("rst_cd",     32'(bus.countdown), 0);
    chk("rst_clr",    32'({bus.bullet_1_clear, bus.bullet_2_clear}), 0);

    // Start pulse, full countdown
    tick(0, 1, 0, 0, 0, 0);
    chk("cd_enter", 32'(bus.state), 1);
    chk("cd_first", 32'(bus.countdown), 179);
    run_countdown();
    chk("play_freeze", 32'(bus.freeze), 0);

    // Hold player_2_hit for 10 frames
    hp = 0; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1, 0, 0);
      if (bus.state == 3'd3) hp++;
      pulses += int'(bus.bullet_1_clear);
      if (i == 0) begin
        chk("hit_p2_lives", 32'(bus.p2_lives), 2);
        chk("hit_p2_inv",   32'(bus.p2_invuln), 1);
      end
    end
    bound = 0;
    while (bus.state == 3'd3 && bound < 100) begin
      bound++;
      tick(0, 0, 0, 0, 0, 0);
      if (bus.state == 3'd3) hp++;
    end
    chk("hp_dwell",    32'(hp), 30);
    chk("hit_pulses",  32'(pulses), 1);
    chk("hp_return",   32'(bus.state), 2);
    chk("held_p2_lives", 32'(bus.p2_lives), 2);

    // Re-hit while still invulnerable
    idle_frames(4);
    tick(0, 0, 0, 1, 0, 0);
    chk("inv_p2_lives", 32'(bus.p2_lives), 2);
    chk("inv_clear",    32'(bus.bullet_1_clear), 0);
    chk("inv_state",    32'(bus.state), 2);
    idle_frames(70);
    chk("inv_expired", 32'(bus.p2_invuln), 0);

    // player_1_hit held through the whole hit pause counts once
    for (int i = 0; i < 50; i++) tick(0, 0, 1, 0, 0, 0);
    chk("held_p1_lives", 32'(bus.p1_lives), 2);
    chk("held_p1_state", 32'(bus.state), 2);
    idle_frames(70);

    // Simultaneous hits: first to 1 life each, then both out
    tick(0, 0, 1, 1, 0, 0);
    chk("dual_p1", 32'(bus.p1_lives), 1);
    chk("dual_p2", 32'(bus.p2_lives), 1);
    chk("dual_hp", 32'(bus.state), 3);
    idle_frames(70);
    chk("dual_back", 32'(bus.state), 2);
    tick(0, 0, 1, 1, 0, 0);
    chk("go_p1",     32'(bus.p1_lives), 0);
    chk("go_p2",     32'(bus.p2_lives), 0);
    chk("go_state",  32'(bus.state), 4);
    chk("go_winner", 32'(bus.winner), 3);
    chk("go_clears", 32'({bus.bullet_1_clear, bus.bullet_2_clear}), 3);
    idle_frames(2);
    chk("go_hold", 32'(bus.winner), 3);
    tick(0, 1, 0, 0, 0, 0);
    chk("restart_state",  32'(bus.state), 1);
    chk("restart_lives",  32'({bus.p1_lives, bus.p2_lives}), 32'h33);
    chk("restart_winner", 32'(bus.winner), 0);
    run_countdown();

    // Bullet-on-bullet and armor together for 3 frames
    pulses = 0; pulses2 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) tick(0, 0, 0, 0, 1, 1);
      else       tick(0, 0, 0, 0, 0, 0);
      pulses  += int'(bus.bullet_1_clear);
      pulses2 += int'(bus.bullet_2_clear);
    end
    chk("bb_clear1", 32'(pulses), 1);
    chk("bb_clear2", 32'(pulses2), 1);
    chk("bb_lives",  32'({bus.p1_lives, bus.p2_lives}), 32'h33);
    chk("bb_state",  32'(bus.state), 2);

    // Reset arriving mid-frame
    tick(0, 0, 1, 0, 0, 0);
    chk("pre_rst_lives", 32'(bus.p1_lives), 2);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_lives", 32'(bus.p1_lives), 3);
    chk("mid_rst_freeze", 32'(bus.freeze), 1);
    chk("mid_rst_clear", 32'(bus.bullet_2_clear), 0);
    chk("mid_rst_inv",   32'(bus.p1_invuln), 0);
    model_reset();
    tick(1, 0, 0, 0, 0, 0);

    // Random level stimulus against the model
    rs = 0; s = 0; h1 = 0; h2 = 0; bob = 0; arm = 0;
    for (int i = 0; i < 8000; i++) begin
      rs = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 24) == 0) s   = !s;
      if ($urandom_range(0, 5)  == 0) h1  = !h1;
      if ($urandom_range(0, 5)  == 0) h2  = !h2;
      if ($urandom_range(0, 7)  == 0) bob = !bob;
      if ($urandom_range(0, 7)  == 0) arm = !arm;
      tick(rs, s, h1, h2, bob, arm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Game-flow controller directly downstream of the bullet/player hit detector.
- Converts level-style hit flags into single accepted hit events, tracks player lives and post-hit invulnerability, and sequences the match through idle, countdown, play, hit-pause and game-over.
- Drives `freeze` to the movement and bullet logic, bullet-clear pulses to the bullet modules, and the lives, winner and countdown values to the display logic.

Parameters:
- LIVES, 3, starting lives per player (1..15).
- INVULN_FRAMES, 60, frames a player ignores further hits after an accepted hit (1..255).
- COUNTDOWN_FRAMES, 180, length of the pre-round countdown in frames (1..255).
- HIT_PAUSE_FRAMES, 30, length of the freeze after a non-fatal hit in frames (1..255).

Ports:
- frame_clk  in  1  frame clock; all state advances once per frame.
- Reset  in  1  asynchronous, active-high.
- start  in  1  start key, level; edge-detected internally.
- player_1_hit  in  1  level; player 1 overlapped by player 2's bullet.
- player_2_hit  in  1  level; player 2 overlapped by player 1's bullet.
- bullet_on_bullet_hit  in  1  level; the two bullets collide.
- armor_hit  in  1  level; a bullet hits the armor.
- state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, HIT_PAUSE=3, GAME_OVER=4.
- freeze  out  1  1 = movement and firing halted.
- bullet_1_clear  out  1  one-frame pulse; despawn player 1's bullet.
- bullet_2_clear  out  1  one-frame pulse; despawn player 2's bullet.
- p1_lives  out  4  player 1 lives remaining.
- p2_lives  out  4  player 2 lives remaining.
- p1_invuln  out  1  player 1 invulnerability counter is non-zero.
- p2_invuln  out  1  player 2 invulnerability counter is non-zero.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- countdown  out  8  frames remaining in COUNTDOWN or HIT_PAUSE; 0 otherwise.

Behaviour:

Reset and timing:
- Reset is asynchronous and active-high; clock is frame_clk.
- On Reset: state=IDLE, lives=LIVES for both players, invuln counters=0, winner=0, countdown=0, clear pulses=0, all edge-detect registers=0.
- freeze is decoded from the registered state: 0 only in PLAY, 1 in every other state.

Edge detection:
- Registered previous values of start and of each hit input are updated every frame in every state.
- A rising edge is current=1 and previous=0.
- An input held high for N frames yields exactly one edge.

Accepted hit (player 2 shown; player 1 is symmetric with bullet_2_clear):
- Conditions: state=PLAY, player_2_hit has a rising edge, p2 invuln counter = 0.
- Effects, all on the next frame edge:
  - p2_lives decrements, saturating at 0.
  - p2 invuln counter loads INVULN_FRAMES.
  - bullet_1_clear pulses for one frame.
- Both players can be hit in the same frame; each hit is accepted independently.

Invulnerability counters:
- Decrement by 1 per frame while non-zero, in COUNTDOWN, PLAY, HIT_PAUSE and GAME_OVER.
- Forced to 0 in IDLE.

Other events, PLAY only:
- Rising edge of bullet_on_bullet_hit: pulse both bullet_1_clear and bullet_2_clear.
- Rising edge of armor_hit: pulse both bullet_1_clear and bullet_2_clear.
- Clear sources are ORed; at most a one-frame pulse per output per frame.
- These events never affect lives.

State transitions:
- IDLE:
  - On a start edge: lives=LIVES, winner=0, countdown=COUNTDOWN_FRAMES-1, go to COUNTDOWN.
- COUNTDOWN:
  - countdown decrements each frame.
  - When countdown=0, go to PLAY.
  - Dwell is exactly COUNTDOWN_FRAMES frames.
- PLAY:
  - If any accepted hit leaves a player with lives=0: go to GAME_OVER.
    - winner=01 if only p2 reaches 0.
    - winner=10 if only p1 reaches 0.
    - winner=11 if both reach 0 in the same frame.
  - Otherwise, if any hit was accepted: countdown=HIT_PAUSE_FRAMES-1, go to HIT_PAUSE.
  - start edges are ignored in PLAY.
- HIT_PAUSE:
  - Hits are ignored.
  - countdown decrements each frame; when it reaches 0, go to PLAY.
  - Dwell is exactly HIT_PAUSE_FRAMES frames.
- GAME_OVER:
  - Lives and winner are held.
  - On a start edge: reload lives, winner=0, countdown=COUNTDOWN_FRAMES-1, go to COUNTDOWN.
- Unused state encodings (5..7) go to IDLE on the next frame.

Boundary cases:
- A hit held high through HIT_PAUSE produces no edge on return to PLAY; it is not counted again.
- A hit that goes high while invulnerable is consumed by the edge detector; it is not counted later.
- Reset mid-frame, in any state, immediately restores all reset values.

Test Plan:
1. Assert Reset for 2 frames, release.
   - Required: state=0, freeze=1, p1_lives=p2_lives=3, winner=0, countdown=0, clears=0.
2. Pulse start 1 frame from IDLE.
   - Required: state=1 for exactly 180 frames, countdown 179→0, then state=2, freeze=0.
3. In PLAY, hold player_2_hit high 10 frames.
   - Required: p2_lives 3→2 once, one bullet_1_clear pulse, p2_invuln=1.
   - Then state=3 for 30 frames, then state=2.
4. Re-pulse player_2_hit 5 frames after returning to PLAY (still invulnerable).
   - Required: p2_lives stays 2, no clear pulse, state stays 2.
5. Reduce both players to 1 life, then raise player_1_hit and player_2_hit in the same frame, both not invulnerable.
   - Required: both lives=0, both clear pulses, state=4, winner=11.
   - Then a start pulse gives state=1, lives=3, winner=0.
6. In PLAY, assert bullet_on_bullet_hit and armor_hit together for 3 frames.
   - Required: a single one-frame pulse on both bullet_1_clear and bullet_2_clear, lives unchanged, state stays 2.
